// File: rtl/alu8_sequencer_if.sv
// Command/response channel bundle for alu8_sequencer.
// master = command issuer / response consumer, slave = the sequencer.
interface alu8_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_flags;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu8_sequencer.sv
// Command sequencer for an external 8-bit ALU: owns acc/flags, adds LOAD, CLRF and shift-add MUL.
// Optional sticky overflow output enabled by defining ALU8_SEQ_STICKY_V_EN.
module alu8_sequencer #(
    parameter int unsigned MUL_BITS = 8,
    parameter logic [7:0]  ACC_RST  = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    alu8_sequencer_if.slave          bus,
    output logic [2:0]               alu_sel,
    output logic [7:0]               alu_a,
    output logic [7:0]               alu_b,
    input  logic [7:0]               alu_y,
    input  logic                     alu_v,
    input  logic                     alu_z,
    input  logic                     alu_c,
    output logic                     flag_vs
);

    typedef enum logic [1:0] {StIdle, StExec, StMul, StResp} state_e;

    state_e     state_q, state_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] flags_q, flags_d;  // {v,z,c}
    logic [2:0] alu_sel_q, alu_sel_d;
    logic [7:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic [2:0] rsp_flags_q, rsp_flags_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic [2:0] step_q, step_d;
    logic       mul_c_q, mul_c_d;
    logic       accept, to_resp, err;
    logic [7:0] prod_cap;

    assign bus.cmd_ready = (state_q == StIdle) & ~rst;
    assign accept        = bus.cmd_valid & bus.cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_flags = rsp_flags_q;
    assign bus.rsp_err   = rsp_err_q;
    assign alu_sel       = alu_sel_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;

    // A MUL step only adds when it issued sel=6; sel=0 marks a skipped bit.
    assign prod_cap = (alu_sel_q == 3'd6) ? alu_y : prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= ACC_RST;
            flags_q     <= 3'b000;
            alu_sel_q   <= 3'd0;
            alu_a_q     <= 8'h00;
            alu_b_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_flags_q <= 3'b000;
            rsp_err_q   <= 1'b0;
            mcand_q     <= 8'h00;
            mplier_q    <= 8'h00;
            prod_q      <= 8'h00;
            step_q      <= 3'd0;
            mul_c_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            flags_q     <= flags_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            rsp_err_q   <= rsp_err_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            prod_q      <= prod_d;
            step_q      <= step_d;
            mul_c_q     <= mul_c_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        flags_d     = flags_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        rsp_err_d   = rsp_err_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        prod_d      = prod_q;
        step_d      = step_q;
        mul_c_d     = mul_c_q;
        to_resp     = 1'b0;
        err         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!bus.cmd_op[3]) begin
                        alu_sel_d = bus.cmd_op[2:0];
                        alu_a_d   = acc_q;
                        alu_b_d   = bus.cmd_data;
                        state_d   = StExec;
                    end else begin
                        case (bus.cmd_op[2:0])
                            3'd0: begin
                                acc_d   = bus.cmd_data;
                                flags_d = {1'b0, bus.cmd_data == 8'h00, 1'b0};
                                to_resp = 1'b1;
                            end
                            3'd1: begin
                                // Step 0 is issued at accept; later steps walk shifted copies.
                                alu_sel_d = bus.cmd_data[0] ? 3'd6 : 3'd0;
                                alu_a_d   = 8'h00;
                                alu_b_d   = acc_q;
                                mcand_d   = {acc_q[6:0], 1'b0};
                                mplier_d  = {1'b0, bus.cmd_data[7:1]};
                                prod_d    = 8'h00;
                                step_d    = 3'd0;
                                mul_c_d   = 1'b0;
                                state_d   = StMul;
                            end
                            3'd2: begin
                                flags_d = 3'b000;
                                to_resp = 1'b1;
                            end
                            default: begin
                                err     = 1'b1;
                                to_resp = 1'b1;
                            end
                        endcase
                    end
                end
            end
            StExec: begin
                acc_d   = alu_y;
                flags_d = {alu_v, alu_z, alu_c};
                to_resp = 1'b1;
            end
            StMul: begin
                prod_d  = prod_cap;
                mul_c_d = mul_c_q | ((alu_sel_q == 3'd6) & alu_c);
                if (step_q == 3'(MUL_BITS - 1)) begin
                    acc_d   = prod_cap;
                    flags_d = {1'b0, prod_cap == 8'h00, mul_c_d};
                    to_resp = 1'b1;
                end else begin
                    alu_sel_d = mplier_q[0] ? 3'd6 : 3'd0;
                    alu_a_d   = prod_cap;
                    alu_b_d   = mcand_q;
                    mcand_d   = {mcand_q[6:0], 1'b0};
                    mplier_d  = {1'b0, mplier_q[7:1]};
                    step_d    = step_q + 3'd1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (to_resp) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_data_d  = acc_d;
            rsp_flags_d = flags_d;
            rsp_err_d   = err;
        end
    end

`ifdef ALU8_SEQ_STICKY_V_EN
    logic flag_vs_q;
    logic vs_set, vs_clr;

    // MUL always finishes with v=0, so only ALU-op captures can set it.
    assign vs_set = (state_q == StExec) & alu_v;
    assign vs_clr = accept & (bus.cmd_op == 4'hA);

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_vs_q <= 1'b0;
        end else if (vs_clr) begin
            flag_vs_q <= 1'b0;
        end else if (vs_set) begin
            flag_vs_q <= 1'b1;
        end
    end

    assign flag_vs = flag_vs_q;
`else
    assign flag_vs = 1'b0;
`endif

endmodule
